mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage.
- Takes the memory fields of the decoded control word (MemRead, MemWrite, Size, lb_lh) plus the effective address and store data.
- Runs a req/ack transaction to the data memory and stalls the pipeline until it completes.
- Handles byte-enable generation, sub-word load extraction with sign/zero extension, alignment checks and an ack timeout.

Parameters:
- TIMEOUT, 16, cycles in REQ without dmem_ack before the access is aborted with bus_err; legal range 2..255.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  MemRead from the control word.
- mem_write  input  1  MemWrite from the control word.
- size  input  2  00 word, 01 half, 10 byte; 11 is illegal.
- lb_lh  input  1  1 = sign-extend sub-word load, 0 = zero-extend.
- addr  input  32  effective byte address.
- wdata  input  32  store data, right-justified.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  32  word address {addr[31:2],2'b00}.
- dmem_be  output  4  byte enables, bit i = byte lane i.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_ack  input  1  memory completion, 1-cycle pulse.
- dmem_rdata  input  32  read word, valid with dmem_ack.
- stall  output  1  freeze upstream pipeline.
- load_data  output  32  extracted, extended load result.
- load_valid  output  1  1-cycle pulse, load_data valid.
- align_exc  output  1  1-cycle pulse: misaligned or illegal access.
- bus_err  output  1  1-cycle pulse: ack timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset forces state IDLE; all outputs 0, load_data 0, timeout counter 0. Reset mid-transaction abandons it with no error pulse; a late dmem_ack is ignored.
- Byte order: little-endian. Lane = addr[1:0].
- Illegal / misaligned access, detected in IDLE:
  - mem_read and mem_write both 1, or size=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Response: align_exc=1 in that same cycle (combinational), no request, stall=0, state stays IDLE.
- State IDLE:
  - dmem_req=0.
  - Legal op present: stall=1 combinationally. Register dmem_addr, dmem_we=mem_write, dmem_be, dmem_wdata, lane, size, lb_lh. Next state REQ.
  - No op: stall=0.
- State REQ:
  - dmem_req=1 and stall=1. Registered address, enable and data outputs are held stable.
  - Counter increments each cycle.
  - dmem_ack=1: capture extracted load data, next state DONE(ok).
  - Else counter==TIMEOUT-1: next state DONE(err).
  - Ack in the same cycle as timeout: ack wins.
- State DONE:
  - dmem_req=0 and stall=0; the pipeline advances this cycle.
  - ok-read: load_valid=1. ok-write: no pulse. err: bus_err=1, load_valid=0.
  - Inputs are ignored. Next state IDLE; the counter clears.
- Latency: a load with ack on the first REQ cycle takes 3 cycles (IDLE, REQ, DONE). stall is high for 2 of them.
- Store lanes:
  - Byte: be = 4'b0001<<lane; wdata[7:0] replicated ×4.
  - Half: be = 0011 (lane 0) or 1100 (lane 2); wdata[15:0] replicated ×2.
  - Word: be = 1111, wdata passed through.
- Loads: dmem_be=1111 and dmem_we=0.
  - Byte: rdata[8*lane+7 : 8*lane], extended per lb_lh.
  - Half: rdata[16*lane[1]+15 : 16*lane[1]], extended per lb_lh.
  - Word: rdata passed through; lb_lh ignored.
- load_data holds its last value until the next successful load.
- dmem_ack outside REQ is ignored.

Test Plan:
- lb, addr=0x1003, lb_lh=1; ack after 2 REQ cycles with rdata=0x80_11_22_33 -> dmem_addr=0x1000, be=1111, stall high 3 cycles, load_data=0xFFFFFF80, load_valid 1 cycle.
- lhu, addr=0x2002, lb_lh=0; ack with rdata=0xBEEF1234 -> load_data=0x0000BEEF. Same with lh -> 0xFFFFBEEF.
- sb, addr=0x3001, wdata=0x000000A5 -> dmem_we=1, be=0010, dmem_wdata=0xA5A5A5A5, no load_valid. sh at 0x3002, wdata=0x1234 -> be=1100, wdata=0x12341234.
- lw at 0x4002; then sh at 0x4001; then size=11 -> align_exc pulse each time, dmem_req never asserts, stall=0.
- lw with no ack, TIMEOUT=16 -> dmem_req high exactly 16 cycles, then bus_err pulse, load_valid=0, IDLE. Second run with ack on the 16th REQ cycle -> load_valid, no bus_err.
- rst asserted during REQ, ack arriving 1 cycle later -> dmem_req=0 and stall=0 after the reset edge, no load_valid/bus_err pulses. The next lw completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory sequencer. Accepts the memory fields of the decoded
// control word, checks the access for legality, runs one req/ack transaction
// to the data memory and stalls the pipeline until that transaction finishes.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   mem_read, mem_write    access type from the control word
//   size                   00 word, 01 half, 10 byte, 11 illegal
//   lb_lh                  1 = sign-extend sub-word loads
//   addr, wdata            effective byte address, right-justified store data
//   dmem_req/we/addr/be/wdata  request side of the data-memory port
//   dmem_ack, dmem_rdata   completion pulse and read word
//   stall                  freeze upstream pipeline
//   load_data, load_valid  extended load result and its 1-cycle strobe
//   align_exc              1-cycle pulse for misaligned / illegal access
//   bus_err                1-cycle pulse when the ack never came
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        lb_lh,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        align_exc,
    output logic        bus_err
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Access attributes kept for the duration of the transaction.
    typedef struct packed {
        logic       we;
        logic [1:0] lane;
        logic [1:0] size;
        logic       sext;
    } req_t;

    state_t state, state_nxt;
    req_t   req_q;
    logic [7:0] cnt;
    logic       err_q;

    logic has_op, illegal, legal;
    logic [NUM_LANES-1:0]      be_nxt;
    logic [NUM_LANES-1:0][7:0] wdata_nxt;
    logic [NUM_LANES-1:0][7:0] rbytes;
    logic [1:0][15:0]          rhalves;
    logic [31:0]               ld_ext;

    // ------------------------------------------------------------------
    // Legality of the op presented in IDLE
    // ------------------------------------------------------------------
    assign has_op  = mem_read | mem_write;
    assign illegal = (mem_read & mem_write) | (size == 2'b11)
                   | ((size == 2'b01) & addr[0])
                   | ((size == 2'b00) & (addr[1:0] != 2'b00));
    assign legal   = has_op & ~illegal;

    // ------------------------------------------------------------------
    // Store lane formatting: each byte lane picks the source byte that
    // the access size replicates into it.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_comb begin
            case (size)
                2'b10:   wdata_nxt[i] = wdata[7:0];
                2'b01:   wdata_nxt[i] = wdata[8*(i%2) +: 8];
                default: wdata_nxt[i] = wdata[8*i +: 8];
            endcase
        end
    end

    always_comb begin
        be_nxt = 4'b1111;
        if (!mem_read) begin
            case (size)
                2'b10:   be_nxt = 4'b0001 << addr[1:0];
                2'b01:   be_nxt = addr[1] ? 4'b1100 : 4'b0011;
                default: be_nxt = 4'b1111;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the returned word using the captured lane
    // ------------------------------------------------------------------
    assign rbytes  = dmem_rdata;
    assign rhalves = dmem_rdata;

    always_comb begin
        case (req_q.size)
            2'b10:   ld_ext = {{24{req_q.sext & rbytes[req_q.lane][7]}},
                               rbytes[req_q.lane]};
            2'b01:   ld_ext = {{16{req_q.sext & rhalves[req_q.lane[1]][15]}},
                               rhalves[req_q.lane[1]]};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state. Ack is checked before the timeout so it wins a tie.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (legal) state_nxt = S_REQ;
            S_REQ:   if (dmem_ack || cnt == 8'(TIMEOUT - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        dmem_req   = 1'b0;
        stall      = 1'b0;
        align_exc  = 1'b0;
        load_valid = 1'b0;
        bus_err    = 1'b0;
        case (state)
            S_IDLE: begin
                stall     = legal;
                align_exc = has_op & illegal;
            end
            S_REQ: begin
                dmem_req = 1'b1;
                stall    = 1'b1;
            end
            S_DONE: begin
                load_valid = ~err_q & ~req_q.we;
                bus_err    = err_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            err_q      <= 1'b0;
            req_q      <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
        end else begin
            cnt <= (state == S_REQ) ? cnt + 8'd1 : 8'd0;

            if (state == S_IDLE && legal) begin
                req_q      <= '{we: mem_write, lane: addr[1:0], size: size, sext: lb_lh};
                dmem_we    <= mem_write;
                dmem_addr  <= {addr[31:2], 2'b00};
                dmem_be    <= be_nxt;
                dmem_wdata <= wdata_nxt;
            end

            // Only meaningful on the cycle REQ exits; an absent ack there
            // means the exit was forced by the timeout.
            if (state == S_REQ) begin
                err_q <= ~dmem_ack;
                if (dmem_ack && !req_q.we) load_data <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, lb_lh = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, stall, load_valid, align_exc, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_be;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_ld = '0;   // last successful load result

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .size(size), .lb_lh(lb_lh),
        .addr(addr), .wdata(wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .align_exc(align_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected load value: shift the addressed bytes down, mask, extend.
    function automatic logic [31:0] model_extract(input logic [31:0] rd, input logic [1:0] lane,
                                                   input int nb, input logic sx);
        logic [31:0] v, mask;
        v = rd >> (8 * lane);
        if (nb == 4) return v;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = v & mask;
        if (sx && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access: present in IDLE, answer with ack after dly extra
    // REQ cycles (dly >= TIMEOUT means never), then check DONE and IDLE.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int dly);
        logic        op, ill, ok;
        int          nb, req_n, exp_n;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        op  = rd | wr;
        ill = (rd && wr) || sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
        nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        ebe = rd ? 4'hF : 4'(((1 << nb) - 1) << a[1:0]);
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];

        @(negedge clk);
        mem_read = rd; mem_write = wr; size = sz; lb_lh = sx; addr = a; wdata = wd;
        #1;
        chk("align_exc", 32'(align_exc), 32'(op && ill));
        chk("stall_idle", 32'(stall), 32'(op && !ill));
        chk("req_idle", 32'(dmem_req), 32'(0));

        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        size = 2'($urandom); addr = $urandom; wdata = $urandom; lb_lh = 1'($urandom);
        if (!op || ill) begin
            chk("req_after_ill", 32'(dmem_req), 32'(0));
            chk("stall_after_ill", 32'(stall), 32'(0));
            return;
        end

        req_n = 0;
        for (int k = 0; k < TIMEOUT + 8; k++) begin
            if (!dmem_req) break;
            if (k == 0) begin
                chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
                chk("dmem_we", 32'(dmem_we), 32'(wr));
                chk("dmem_be", 32'(dmem_be), 32'(ebe));
                if (wr) chk("dmem_wdata", dmem_wdata, ewd);
            end
            chk("stall_req", 32'(stall), 32'(1));
            dmem_ack   = (k == dly);
            dmem_rdata = (k == dly) ? rdat : $urandom;
            req_n++;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        chk("req_bound", 32'(dmem_req), 32'(0));

        ok    = dly < TIMEOUT;
        exp_n = ok ? dly + 1 : TIMEOUT;
        if (ok && rd) model_ld = model_extract(rdat, a[1:0], nb, sx);
        chk("req_cycles", 32'(req_n), 32'(exp_n));
        chk("load_valid", 32'(load_valid), 32'(ok && rd));
        chk("bus_err", 32'(bus_err), 32'(!ok));
        chk("stall_done", 32'(stall), 32'(0));
        chk("load_data", load_data, model_ld);

        // A stray ack in DONE must be ignored.
        dmem_ack = 1'($urandom); dmem_rdata = $urandom;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle_req", 32'(dmem_req), 32'(0));
        chk("idle_pulses", 32'({load_valid, bus_err, stall}), 32'(0));
        chk("load_hold", load_data, model_ld);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", 32'({dmem_req, dmem_we, stall, load_valid, align_exc, bus_err}), 32'(0));
        chk("rst_addr", dmem_addr, 32'(0));
        chk("rst_be", 32'(dmem_be), 32'(0));
        chk("rst_ld", load_data, 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios
        run_txn(1, 0, 2'b10, 1, 32'h1003, 32'h0, 32'h80112233, 1);    // lb
        run_txn(1, 0, 2'b01, 0, 32'h2002, 32'h0, 32'hBEEF1234, 0);    // lhu
        run_txn(1, 0, 2'b01, 1, 32'h2002, 32'h0, 32'hBEEF1234, 0);    // lh
        run_txn(0, 1, 2'b10, 0, 32'h3001, 32'hA5, 32'h0, 0);          // sb
        run_txn(0, 1, 2'b01, 0, 32'h3002, 32'h1234, 32'h0, 2);        // sh
        run_txn(1, 0, 2'b00, 0, 32'h4002, 32'h0, 32'h0, 0);           // misaligned lw
        run_txn(0, 1, 2'b01, 0, 32'h4001, 32'h0, 32'h0, 0);           // misaligned sh
        run_txn(1, 0, 2'b11, 0, 32'h4000, 32'h0, 32'h0, 0);           // size 11
        run_txn(1, 1, 2'b00, 0, 32'h4000, 32'h0, 32'h0, 0);           // read+write
        run_txn(1, 0, 2'b00, 0, 32'h5000, 32'h0, 32'h0, NO_ACK);      // timeout
        run_txn(1, 0, 2'b00, 0, 32'h5004, 32'h0, 32'hCAFEF00D, TIMEOUT - 1); // ack on last cycle
        chk("plan_lh", model_ld, 32'hCAFEF00D);

        // Reset in the middle of REQ, late ack afterwards
        @(negedge clk);
        mem_read = 1'b1; size = 2'b00; addr = 32'h6000;
        @(negedge clk);
        mem_read = 1'b0;
        chk("rst_mid_req", 32'(dmem_req), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        chk("rst_req", 32'({dmem_req, stall}), 32'(0));
        chk("rst_pulses", 32'({load_valid, bus_err}), 32'(0));
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack", 32'({dmem_req, stall, load_valid, bus_err}), 32'(0));
        model_ld = '0;
        chk("rst_ld_clear", load_data, model_ld);
        run_txn(1, 0, 2'b00, 0, 32'h6000, 32'h0, 32'h0BADF00D, 0);

        // Randomized accesses
        for (int t = 0; t < 300; t++) begin
            logic rd, wr;
            int   dly;
            rd  = 1'($urandom);
            wr  = ($urandom_range(0, 9) == 0) ? rd : ~rd;
            dly = ($urandom_range(0, 7) == 0) ? NO_ACK : $urandom_range(0, TIMEOUT - 1);
            run_txn(rd, wr, 2'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFA) : $urandom,
                    $urandom, $urandom, dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
